cluster_clock_gate_ctrl: RTL and testbench

//  Idle-driven clock-gate controller for the cluster root clock. Runs on the ungated

---
 rtl/cluster_clock_gate_pkg.sv | 16 +
 rtl/cluster_clock_gate_ctrl.sv | 132 +++++++++++++
 tb/tb_cluster_clock_gate_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cluster_clock_gate_pkg.sv
// Shared types and defaults for the cluster root-clock gate controller.
package cluster_clock_gate_pkg;

   typedef enum logic [2:0] {
      RUN,
      IDLE,
      DRAIN,
      GATED,
      WAKE
   } ctrl_state_e;

   localparam int IDLE_CNT_WIDTH_DEFAULT = 8;
   localparam int WAKE_LAT_DEFAULT       = 2;
   localparam int STAT_WIDTH_DEFAULT     = 32;

endpackage

// File: rtl/cluster_clock_gate_ctrl.sv
// Idle-driven enable controller for the cluster ICG: idle count, interconnect drain,
// gate, and timed wake with a settle window before acknowledging.
module cluster_clock_gate_ctrl
   import cluster_clock_gate_pkg::*;
#(
   parameter int IDLE_CNT_WIDTH = IDLE_CNT_WIDTH_DEFAULT,
   parameter int WAKE_LAT       = WAKE_LAT_DEFAULT,
   parameter int STAT_WIDTH     = STAT_WIDTH_DEFAULT
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      test_mode_i,
   input  logic                      cfg_en_i,
   input  logic [IDLE_CNT_WIDTH-1:0] cfg_idle_thr_i,
   input  logic                      busy_i,
   input  logic                      wake_req_i,
   output logic                      drain_req_o,
   input  logic                      drain_ack_i,
   output logic                      clk_en_o,
   output logic                      gated_o,
   output logic                      wake_ack_o,
   input  logic                      stat_clr_i,
   output logic [STAT_WIDTH-1:0]     stat_gated_cyc_o
);

   localparam int WCNT_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
   localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WAKE_LAT - 1);

   if (WAKE_LAT < 1) begin : g_bad_wake_lat
      $error("cluster_clock_gate_ctrl: WAKE_LAT must be at least 1");
   end

   ctrl_state_e               state_q;
   logic [IDLE_CNT_WIDTH-1:0] idle_cnt_q;
   logic [IDLE_CNT_WIDTH-1:0] thr_q;
   logic [WCNT_W-1:0]         wcnt_q;
   logic                      clk_en_q;
   logic                      drain_req_q;
   logic                      gated_q;
   logic                      wake_ack_q;
   logic [STAT_WIDTH-1:0]     stat_q;
   logic                      leave;

   // Any activity, wake request or loss of permission pulls us back toward RUN.
   assign leave = busy_i | wake_req_i | ~cfg_en_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= RUN;
         idle_cnt_q  <= '0;
         thr_q       <= '0;
         wcnt_q      <= '0;
         clk_en_q    <= 1'b1;
         drain_req_q <= 1'b0;
         gated_q     <= 1'b0;
         wake_ack_q  <= 1'b0;
      end else begin
         wake_ack_q <= 1'b0;
         case (state_q)
            RUN: begin
               if (cfg_en_i && (cfg_idle_thr_i != '0) && !busy_i && !wake_req_i) begin
                  state_q    <= IDLE;
                  idle_cnt_q <= '0;
                  thr_q      <= cfg_idle_thr_i;
               end
            end
            IDLE: begin
               if (leave) begin
                  state_q <= RUN;
               end else begin
                  idle_cnt_q <= idle_cnt_q + IDLE_CNT_WIDTH'(1);
                  if (idle_cnt_q == thr_q - IDLE_CNT_WIDTH'(1)) begin
                     state_q     <= DRAIN;
                     drain_req_q <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               // Abort beats a coincident ack: the clock is never cut under live traffic.
               if (leave) begin
                  state_q     <= RUN;
                  drain_req_q <= 1'b0;
               end else if (drain_ack_i) begin
                  state_q  <= GATED;
                  clk_en_q <= 1'b0;
                  gated_q  <= 1'b1;
               end
            end
            GATED: begin
               if (leave) begin
                  state_q  <= WAKE;
                  clk_en_q <= 1'b1;
                  wcnt_q   <= WCNT_INIT;
               end
            end
            WAKE: begin
               if (wcnt_q == '0) begin
                  state_q     <= RUN;
                  drain_req_q <= 1'b0;
                  gated_q     <= 1'b0;
                  wake_ack_q  <= 1'b1;
               end else begin
                  wcnt_q <= wcnt_q - WCNT_W'(1);
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stat_q <= '0;
      end else if (stat_clr_i) begin
         stat_q <= '0;
      end else if (state_q == GATED && stat_q != '1) begin
         stat_q <= stat_q + STAT_WIDTH'(1);
      end
   end

   assign clk_en_o         = clk_en_q | test_mode_i;
   assign drain_req_o      = drain_req_q;
   assign gated_o          = gated_q;
   assign wake_ack_o       = wake_ack_q;
   assign stat_gated_cyc_o = stat_q;

   a_ack_held_while_gated: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (state_q == GATED || state_q == WAKE) |-> drain_ack_i
   ) else $error("drain_ack_i dropped while clock gated");

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Scenario bench for cluster_clock_gate_ctrl: expected outputs are queued per step and
// compared once the DUT has produced them.
module tb_cluster_clock_gate_ctrl;

   localparam int TW = 8;
   localparam int SW = 5;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          test_mode_i = 1'b0;
   logic          cfg_en_i = 1'b1;
   logic [TW-1:0] cfg_idle_thr_i = 8'd4;
   logic          busy_i = 1'b1;
   logic          wake_req_i = 1'b0;
   logic          drain_req_o;
   logic          drain_ack_i = 1'b0;
   logic          clk_en_o;
   logic          gated_o;
   logic          wake_ack_o;
   logic          stat_clr_i = 1'b0;
   logic [SW-1:0] stat_gated_cyc_o;

   cluster_clock_gate_ctrl #(
      .IDLE_CNT_WIDTH(TW),
      .WAKE_LAT      (2),
      .STAT_WIDTH    (SW)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .test_mode_i     (test_mode_i),
      .cfg_en_i        (cfg_en_i),
      .cfg_idle_thr_i  (cfg_idle_thr_i),
      .busy_i          (busy_i),
      .wake_req_i      (wake_req_i),
      .drain_req_o     (drain_req_o),
      .drain_ack_i     (drain_ack_i),
      .clk_en_o        (clk_en_o),
      .gated_o         (gated_o),
      .wake_ack_o      (wake_ack_o),
      .stat_clr_i      (stat_clr_i),
      .stat_gated_cyc_o(stat_gated_cyc_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string        tag;
      logic [SW+3:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // {clk_en, drain_req, gated, wake_ack, stat}
   function automatic logic [SW+3:0] ev(input logic ce, input logic dr, input logic g,
                                        input logic wa, input int st);
      return {ce, dr, g, wa, SW'(st)};
   endfunction

   task automatic chk(input string tag, input logic [SW+3:0] act, input logic [SW+3:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b want %b (ce dr g wa stat)", tag, act, exp);
      end
   endtask

   task automatic pop_cmp();
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("sb_empty", '1, '0);
      end else begin
         e = sb_q.pop_front();
         chk(e.tag, {clk_en_o, drain_req_o, gated_o, wake_ack_o, stat_gated_cyc_o}, e.exp);
      end
   endtask

   // Expect a value after the next active edge.
   task automatic step(input string tag, input logic [SW+3:0] exp);
      sb_q.push_back('{tag, exp});
      @(posedge clk_i);
      #1;
      pop_cmp();
   endtask

   // Expect a value right now (reset and combinational paths).
   task automatic now(input string tag, input logic [SW+3:0] exp);
      sb_q.push_back('{tag, exp});
      #1;
      pop_cmp();
   endtask

   initial begin
      repeat (2) @(posedge clk_i);
      #1;
      now("reset", ev(1, 0, 0, 0, 0));
      rst_ni = 1'b1;
      step("run_busy", ev(1, 0, 0, 0, 0));
      step("run_busy", ev(1, 0, 0, 0, 0));

      // 1: thr=4, busy falls -> drain_req after 5 edges; ack 2 cycles later gates.
      busy_i = 1'b0;
      for (int i = 0; i < 4; i++) step("idle_wait", ev(1, 0, 0, 0, 0));
      step("drain_req", ev(1, 1, 0, 0, 0));
      step("drain_noack", ev(1, 1, 0, 0, 0));
      drain_ack_i = 1'b1;
      step("gate", ev(0, 1, 1, 0, 0));

      // 2: ten gated cycles, wake pulse, ack after WAKE_LAT+1.
      for (int i = 1; i <= 9; i++) step("gated_cnt", ev(0, 1, 1, 0, i));
      wake_req_i = 1'b1;
      step("wake_clk_en", ev(1, 1, 1, 0, 10));
      wake_req_i = 1'b0;
      step("wake_settle", ev(1, 1, 1, 0, 10));
      step("wake_ack", ev(1, 0, 0, 1, 10));
      drain_ack_i = 1'b0;
      busy_i = 1'b1;
      step("wake_ack_pulse", ev(1, 0, 0, 0, 10));

      // 3a: busy back in IDLE at cnt=2 -> no drain.
      busy_i = 1'b0;
      for (int i = 0; i < 3; i++) step("idle_abort_w", ev(1, 0, 0, 0, 10));
      busy_i = 1'b1;
      for (int i = 0; i < 4; i++) step("idle_abort", ev(1, 0, 0, 0, 10));

      // 3b: busy together with ack in DRAIN -> abort.
      busy_i = 1'b0;
      for (int i = 0; i < 4; i++) step("drain_abort_w", ev(1, 0, 0, 0, 10));
      step("drain_abort_req", ev(1, 1, 0, 0, 10));
      busy_i = 1'b1;
      drain_ack_i = 1'b1;
      step("drain_abort", ev(1, 0, 0, 0, 10));
      drain_ack_i = 1'b0;
      step("drain_abort_run", ev(1, 0, 0, 0, 10));

      // 4a: thr=0, then cfg_en=0, never gate.
      busy_i = 1'b0;
      cfg_idle_thr_i = 8'd0;
      for (int i = 0; i < 100; i++) step("thr0", ev(1, 0, 0, 0, 10));
      cfg_idle_thr_i = 8'd4;
      cfg_en_i = 1'b0;
      for (int i = 0; i < 100; i++) step("cfg_dis", ev(1, 0, 0, 0, 10));
      busy_i = 1'b1;
      cfg_en_i = 1'b1;
      step("cfg_back", ev(1, 0, 0, 0, 10));

      // 4b: thr latched at IDLE entry; change to 1 is ignored.
      busy_i = 1'b0;
      step("thr_latch_e1", ev(1, 0, 0, 0, 10));
      cfg_idle_thr_i = 8'd1;
      for (int i = 0; i < 3; i++) step("thr_latch_w", ev(1, 0, 0, 0, 10));
      step("thr_latch_req", ev(1, 1, 0, 0, 10));
      drain_ack_i = 1'b1;
      step("thr_latch_gate", ev(0, 1, 1, 0, 10));
      cfg_idle_thr_i = 8'd4;

      // 5: test mode forces enable only; clear priority; saturation.
      test_mode_i = 1'b1;
      now("tm_force", ev(1, 1, 1, 0, 10));
      step("tm_gated", ev(1, 1, 1, 0, 11));
      test_mode_i = 1'b0;
      now("tm_release", ev(0, 1, 1, 0, 11));
      stat_clr_i = 1'b1;
      step("stat_clr", ev(0, 1, 1, 0, 0));
      stat_clr_i = 1'b0;
      for (int i = 1; i <= 34; i++) step("stat_sat", ev(0, 1, 1, 0, (i > 31) ? 31 : i));

      // 6: async reset while GATED, then while DRAIN.
      rst_ni = 1'b0;
      now("rst_gated", ev(1, 0, 0, 0, 0));
      busy_i = 1'b1;
      drain_ack_i = 1'b0;
      #1;
      rst_ni = 1'b1;
      step("rst_run", ev(1, 0, 0, 0, 0));
      busy_i = 1'b0;
      for (int i = 0; i < 4; i++) step("rst_idle_w", ev(1, 0, 0, 0, 0));
      step("rst_drain", ev(1, 1, 0, 0, 0));
      rst_ni = 1'b0;
      now("rst_drain_async", ev(1, 0, 0, 0, 0));
      busy_i = 1'b1;
      #1;
      rst_ni = 1'b1;
      step("rst_release", ev(1, 0, 0, 0, 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
